// File: rtl/filterbank_sequencer.sv
// Windowing-pass sequencer: tracks the sample RAM write pointer and ready blocks,
// issues the 64x8 tap address sequence, and produces pipelined MAC/write strobes.
//
// state | meaning
// IDLE  | waiting for a pending block while enable is high
// RUN   | issuing 512 taps, j inner (0..7), i outer (0..63)
// DRAIN | PIPE_LAT+1 cycles for the last products and the final write
module filterbank_sequencer #(
    parameter int PIPE_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic       enable,
    input  logic       clr_overrun,
    output logic [8:0] sample_wr_addr,
    output logic [8:0] rd_sample_addr,
    output logic [8:0] rd_coef_addr,
    output logic       tap_valid,
    output logic       acc_clr,
    output logic       acc_en,
    output logic       out_we,
    output logic [5:0] out_idx,
    output logic       busy,
    output logic       block_done,
    output logic       overrun
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [2:0] DRAIN_LAST = 3'(PIPE_LAT);

    state_t              state_q, state_d;
    logic [8:0]          wr_addr_q, wr_addr_d;
    logic [8:0]          newest_q, newest_d;
    logic [8:0]          base_q, base_d;
    logic                pending_q, pending_d;
    logic                overrun_q, overrun_d;
    logic [5:0]          i_q, i_d;
    logic [2:0]          j_q, j_d;
    logic [2:0]          drain_q, drain_d;
    logic [8:0]          coef_hold_q, coef_hold_d;
    logic [8:0]          samp_hold_q, samp_hold_d;
    logic [PIPE_LAT-1:0] en_dly_q, en_dly_d;
    logic [PIPE_LAT-1:0] clr_dly_q, clr_dly_d;
    logic [PIPE_LAT:0]   we_dly_q, we_dly_d;
    logic [PIPE_LAT:0][5:0] idx_dly_q, idx_dly_d;

    logic       block_complete;
    logic       start;
    logic       last_tap;
    logic [8:0] tap_addr;
    logic [8:0] tap_samp;

    always_comb begin
        tap_valid      = (state_q == RUN);
        tap_addr       = {j_q, i_q};
        tap_samp       = base_q - tap_addr;
        block_complete = sample_valid && (wr_addr_q[4:0] == 5'd31);
        start          = (state_q == IDLE) && pending_q && enable;
        last_tap       = (i_q == 6'd63) && (j_q == 3'd7);

        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        drain_d   = drain_q;
        wr_addr_d = sample_valid ? wr_addr_q + 9'd1 : wr_addr_q;
        newest_d  = block_complete ? wr_addr_q : newest_q;
        base_d    = start ? newest_q : base_q;

        // A completion landing on the start cycle refills pending and is not an overrun.
        if (block_complete)
            pending_d = 1'b1;
        else if (start)
            pending_d = 1'b0;
        else
            pending_d = pending_q;

        if (block_complete && pending_q && !start)
            overrun_d = 1'b1;
        else if (clr_overrun)
            overrun_d = 1'b0;
        else
            overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (start)
                    state_d = RUN;
            end
            RUN: begin
                j_d = j_q + 3'd1;
                if (j_q == 3'd7)
                    i_d = i_q + 6'd1;
                if (last_tap) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST)
                    state_d = IDLE;
                else
                    drain_d = drain_q + 3'd1;
            end
            default: state_d = IDLE;
        endcase

        coef_hold_d = tap_valid ? tap_addr : coef_hold_q;
        samp_hold_d = tap_valid ? tap_samp : samp_hold_q;

        en_dly_d     = '0;
        clr_dly_d    = '0;
        we_dly_d     = '0;
        idx_dly_d    = '0;
        en_dly_d[0]  = tap_valid;
        clr_dly_d[0] = tap_valid && (j_q == 3'd0);
        we_dly_d[0]  = tap_valid && (j_q == 3'd7);
        idx_dly_d[0] = i_q;
        for (int k = 1; k < PIPE_LAT; k++) begin
            en_dly_d[k]  = en_dly_q[k-1];
            clr_dly_d[k] = clr_dly_q[k-1];
        end
        for (int k = 1; k <= PIPE_LAT; k++) begin
            we_dly_d[k]  = we_dly_q[k-1];
            idx_dly_d[k] = idx_dly_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            newest_q    <= '0;
            base_q      <= '0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            i_q         <= '0;
            j_q         <= '0;
            drain_q     <= '0;
            coef_hold_q <= '0;
            samp_hold_q <= '0;
            en_dly_q    <= '0;
            clr_dly_q   <= '0;
            we_dly_q    <= '0;
            idx_dly_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            newest_q    <= newest_d;
            base_q      <= base_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            i_q         <= i_d;
            j_q         <= j_d;
            drain_q     <= drain_d;
            coef_hold_q <= coef_hold_d;
            samp_hold_q <= samp_hold_d;
            en_dly_q    <= en_dly_d;
            clr_dly_q   <= clr_dly_d;
            we_dly_q    <= we_dly_d;
            idx_dly_q   <= idx_dly_d;
        end
    end

    assign sample_wr_addr = wr_addr_q;
    assign rd_coef_addr   = tap_valid ? tap_addr : coef_hold_q;
    assign rd_sample_addr = tap_valid ? tap_samp : samp_hold_q;
    assign acc_en         = en_dly_q[PIPE_LAT-1];
    assign acc_clr        = clr_dly_q[PIPE_LAT-1];
    assign out_we         = we_dly_q[PIPE_LAT];
    assign out_idx        = idx_dly_q[PIPE_LAT];
    assign busy           = (state_q != IDLE);
    assign block_done     = (state_q == DRAIN) && (drain_q == DRAIN_LAST);
    assign overrun        = overrun_q;

endmodule
